// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: operand request and result handshake bundle
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide add/subtract sequenced through one 4-bit slice, LSB nibble first
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_q, cout_q, ovf_q;
  logic [3:0]       a_n, b_n, lo;
  logic [4:0]       full;
  logic             last, accept;
  assign a_n    = a_q[4*int'(cnt_q) +: 4];
  assign b_n    = b_q[4*int'(cnt_q) +: 4];
  assign lo     = {1'b0, a_n[2:0]} + {1'b0, b_n[2:0]} + {3'b0, c_q};
  assign full   = {1'b0, a_n} + {1'b0, b_n} + {4'b0, c_q};
  assign last   = cnt_q == CW'(NIB - 1);
  assign accept = bus.in_valid && state_q == IDLE;
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next state: accept -> RUN, last nibble -> DONE, sink handshake -> IDLE
  always_comb
    state_d = (state_q == IDLE && bus.in_valid) ? RUN :
              (state_q == RUN && last)          ? DONE :
              (state_q == DONE && bus.out_ready) ? IDLE : state_q;
  // handshake outputs decoded from state only
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.out_sum   = sum_q;
    bus.out_cout  = cout_q;
    bus.out_ovf   = ovf_q;
  end
  // operand latch on accept, one slice step per RUN cycle; B is pre-inverted for subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      a_q   <= bus.in_a;
      b_q   <= bus.in_b ^ {WIDTH{bus.in_sub}};
      c_q   <= bus.in_sub | bus.in_cin;
    end else if (state_q == RUN) begin
      sum_q[4*int'(cnt_q) +: 4] <= full[3:0];
      c_q                       <= full[4];
      cnt_q                     <= last ? cnt_q : cnt_q + 1'b1;
      cout_q                    <= last ? full[4] : cout_q;
      ovf_q                     <= last ? lo[3] ^ full[4] : ovf_q;
    end
  end
endmodule
